spidergon_vc_arbiter: RTL and testbench
=======================================

SPIDERGON_VC_ARBITER -- requirements
Module: spidergon_vc_arbiter

Interface
REQ-001 Parameter NUM_OF_INPUTS, default 4, SHALL set the number of input ports competing for one output port (local, clockwise, anti-clockwise, across).
REQ-002 Parameter NUM_OF_VIRTUAL_CHANNELS, default 2, SHALL set the number of downstream VCs on the output port.
REQ-003 Parameter VC_CREDITS, default 2, SHALL set the downstream buffer depth per VC, in flits.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Port in_req, input, NUM_OF_INPUTS, SHALL flag that input i presents a flit at its buffer head.
REQ-007 Port in_flit_type, input, 2*NUM_OF_INPUTS, SHALL carry the 2-bit head/tail code of input i's flit in bits [2i+1:2i].
REQ-008 Port credit_return, input, NUM_OF_VIRTUAL_CHANNELS, SHALL pulse for one cycle when downstream frees one slot of VC v.
REQ-009 Port in_grant, output, NUM_OF_INPUTS, SHALL be one-hot or zero; bit i means input i's flit is consumed this cycle.
REQ-010 Port out_valid, output, 1, SHALL equal the OR of in_grant.
REQ-011 Port out_vc, output, clog2(NUM_OF_VIRTUAL_CHANNELS) (min 1), SHALL give the VC of the granted flit; zero when out_valid is low.
REQ-012 Port vc_busy, output, NUM_OF_VIRTUAL_CHANNELS, SHALL flag VCs currently owned by a packet.

Function
REQ-013 Flit codes SHALL be: 01 head, 11 single-flit header (head and tail), 10 body, 00 tail.
REQ-014 VC allocation: an input with in_req high, code 01 or 11, and no owned VC SHALL be eligible; one eligible input per cycle SHALL receive the lowest-index free VC, registered at the clock edge.
REQ-015 Head flit grant latency SHALL be at least 1 cycle after allocation (no same-cycle allocate-and-traverse).
REQ-016 Switch allocation: an input with in_req high, an owned VC, and credit[vc] > 0 SHALL be eligible; at most one SHALL be granted per cycle, combinationally from registered state and current inputs.
REQ-017 Switch and VC allocators SHALL each keep an independent round-robin pointer; after granting input i the pointer SHALL move to (i+1) mod NUM_OF_INPUTS; with no grant the pointer SHALL hold.
REQ-018 Credit counter per VC SHALL decrement on grant, increment on credit_return, and stay unchanged when both occur in the same cycle.
REQ-019 credit_return at credit == VC_CREDITS SHALL be ignored (saturate) and SHALL fire a simulation assertion.
REQ-020 A granted flit with code 00 or 11 SHALL release its VC and clear the input's ownership at that edge; the freed VC SHALL be allocatable from the next cycle, not the same cycle.
REQ-021 A body/tail flit from an input with no owned VC SHALL never be granted and SHALL fire an assertion; a head flit from an input already owning a VC SHALL be ignored for allocation.
REQ-022 An input SHALL own at most one VC; a VC SHALL have at most one owner.

Reset
REQ-023 On reset low, asynchronously: all VCs free, ownership cleared, credits = VC_CREDITS, both pointers = 0; in_grant, out_valid, out_vc, vc_busy = 0.
REQ-024 Reset asserted mid-packet SHALL drop all ownership; after release, the interrupted input's next flit SHALL require a new head flit.

Configuration
REQ-025 Macro NOC_ARB_FIXED_PRIO_EN defined: both allocators SHALL use fixed priority, lowest input index wins, pointers removed; undefined: round-robin per REQ-017.

Structure
REQ-026 Package noc_pkg SHALL hold HEAD_TAIL width and flit codes HEAD_FLIT, HEADER, BODY_FLIT, TAIL_FLIT.
REQ-027 Sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on enable) SHALL be instantiated twice: VC allocator and switch allocator.

Verification
REQ-028 Single input 1 sends 11, no other traffic -> VC 0 allocated at cycle 1, in_grant=0010, out_vc=0 at cycle 2, vc_busy=00 at cycle 3.
REQ-029 Inputs 1 and 2 send 01 simultaneously -> input 1 gets VC 0, input 2 gets VC 1 one cycle later; body flits then alternate grants 1,2,1,2.
REQ-030 Input 0 sends 01 + 3 bodies, no credit_return, VC_CREDITS=2 -> exactly 2 grants, then stall; one credit_return pulse -> exactly one further grant.
REQ-031 All 4 inputs send 01 with 2 VCs -> 2 inputs allocated; the third is allocated the cycle after the first tail is granted, never the same cycle.
REQ-032 grant and credit_return on the same VC in the same cycle -> credit unchanged; credit_return at full credit -> assertion fires, counter stays 2.
REQ-033 Reset low mid-packet with vc_busy=11 -> outputs 0 immediately (asynchronous); after release, body flit on that input is never granted.

Source files
------------

// File: rtl/noc_pkg.sv
// Flit head/tail encodings shared by the spidergon output-port arbiter.
// Helpers classify a code as opening or closing a packet.
package noc_pkg;

   localparam int HEAD_TAIL = 2;

   localparam logic [HEAD_TAIL-1:0] TAIL_FLIT = 2'b00;
   localparam logic [HEAD_TAIL-1:0] HEAD_FLIT = 2'b01;
   localparam logic [HEAD_TAIL-1:0] BODY_FLIT = 2'b10;
   localparam logic [HEAD_TAIL-1:0] HEADER    = 2'b11;

   function automatic logic is_head(input logic [HEAD_TAIL-1:0] code);
      return (code == HEAD_FLIT) || (code == HEADER);
   endfunction

   function automatic logic is_tail(input logic [HEAD_TAIL-1:0] code);
      return (code == TAIL_FLIT) || (code == HEADER);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter; round-robin pointer advances past the winner when en is high.
// With NOC_ARB_FIXED_PRIO_EN defined it becomes lowest-index-wins and keeps no state.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);

`ifdef NOC_ARB_FIXED_PRIO_EN
   logic unused_ok;
   assign unused_ok = ^{clk, reset, en};

   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;

   // Scan offsets from the pointer; the inner loop keeps every bit index constant.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      ptr_d = ptr_q;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i == (int'(ptr_q) + k) % N)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               if (en) ptr_d = PW'((i + 1) % N);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`endif

endmodule

// File: rtl/spidergon_vc_arbiter.sv
// Output-port arbiter: VC allocation for head flits, then credit-gated switch allocation.
// Define NOC_ARB_FIXED_PRIO_EN for fixed lowest-index priority in both allocators.
module spidergon_vc_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_OF_INPUTS           = 4,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int VC_CREDITS              = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_OF_INPUTS-1:0]             in_req,
   input  logic [HEAD_TAIL*NUM_OF_INPUTS-1:0]   in_flit_type,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0]   credit_return,
   output logic [NUM_OF_INPUTS-1:0]             in_grant,
   output logic                                 out_valid,
   output logic [((NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1)-1:0] out_vc,
   output logic [NUM_OF_VIRTUAL_CHANNELS-1:0]   vc_busy
);

   localparam int N   = NUM_OF_INPUTS;
   localparam int V   = NUM_OF_VIRTUAL_CHANNELS;
   localparam int VCW = (V > 1) ? $clog2(V) : 1;
   localparam int CW  = $clog2(VC_CREDITS + 1);

   logic [N-1:0]   own_valid_q, own_valid_d;
   logic [VCW-1:0] own_vc_q [N];
   logic [VCW-1:0] own_vc_d [N];
   logic [V-1:0]   vc_busy_q, vc_busy_d;

   logic [N-1:0]   va_req, va_grant, sa_req, sa_grant, tail_of;
   logic [V-1:0]   credit_nz;
   logic           any_free;
   logic [VCW-1:0] free_vc;

   // Lowest-index free VC, taken from registered state so a freed VC waits one cycle.
   always_comb begin
      any_free = 1'b0;
      free_vc  = '0;
      for (int v = V - 1; v >= 0; v--) begin
         if (!vc_busy_q[v]) begin
            any_free = 1'b1;
            free_vc  = VCW'(v);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_input
      logic [HEAD_TAIL-1:0] code;
      assign code         = in_flit_type[HEAD_TAIL*gi +: HEAD_TAIL];
      assign va_req[gi]   = in_req[gi] & is_head(code) & ~own_valid_q[gi] & any_free;
      assign sa_req[gi]   = in_req[gi] & own_valid_q[gi] & credit_nz[own_vc_q[gi]];
      assign tail_of[gi]  = is_tail(code);

      always @(posedge clk) begin
         if (reset)
            assert (!(in_req[gi] && !is_head(code) && !own_valid_q[gi]))
               else $warning("input %0d presents a body/tail flit without an owned VC", gi);
      end
   end

   rr_arbiter #(.N(N)) u_vc_alloc (
      .clk   (clk),
      .reset (reset),
      .req   (va_req),
      .en    (|va_req),
      .grant (va_grant)
   );

   rr_arbiter #(.N(N)) u_sw_alloc (
      .clk   (clk),
      .reset (reset),
      .req   (sa_req),
      .en    (|sa_req),
      .grant (sa_grant)
   );

   assign in_grant  = sa_grant;
   assign out_valid = |sa_grant;
   assign vc_busy   = vc_busy_q;

   always_comb begin
      out_vc = '0;
      for (int i = 0; i < N; i++) begin
         if (sa_grant[i]) out_vc = own_vc_q[i];
      end
   end

   // Release and allocation never collide: the releasing input and VC are owned, the allocated ones are not.
   always_comb begin
      own_valid_d = own_valid_q;
      own_vc_d    = own_vc_q;
      vc_busy_d   = vc_busy_q;
      for (int i = 0; i < N; i++) begin
         if (sa_grant[i] && tail_of[i]) begin
            own_valid_d[i]            = 1'b0;
            vc_busy_d[own_vc_q[i]]    = 1'b0;
         end
         if (va_grant[i]) begin
            own_valid_d[i]     = 1'b1;
            own_vc_d[i]        = free_vc;
            vc_busy_d[free_vc] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         own_valid_q <= '0;
         vc_busy_q   <= '0;
         for (int i = 0; i < N; i++) own_vc_q[i] <= '0;
      end else begin
         own_valid_q <= own_valid_d;
         vc_busy_q   <= vc_busy_d;
         own_vc_q    <= own_vc_d;
      end
   end

   for (genvar gi = 0; gi < V; gi++) begin : g_credit
      logic [CW-1:0] credit_q, credit_d;
      logic          dec, inc, full;

      assign full          = (credit_q == CW'(VC_CREDITS));
      assign dec           = out_valid && (out_vc == VCW'(gi));
      assign inc           = credit_return[gi] && (!full || dec);
      assign credit_nz[gi] = (credit_q != '0);

      always_comb begin
         credit_d = credit_q;
         if (inc && !dec)      credit_d = credit_q + 1'b1;
         else if (dec && !inc) credit_d = credit_q - 1'b1;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) credit_q <= CW'(VC_CREDITS);
         else        credit_q <= credit_d;
      end

      always @(posedge clk) begin
         if (reset)
            assert (!(credit_return[gi] && full && !dec))
               else $warning("credit return on VC %0d at full credit ignored", gi);
      end
   end

endmodule

// File: tb/tb_spidergon_vc_arbiter.sv
// Randomized and directed bench for spidergon_vc_arbiter against a queue-based packet model.
// Each step drives flit sources, predicts grant/VC/busy from ownership and credit bookkeeping.
module tb_spidergon_vc_arbiter;
   import noc_pkg::*;

   localparam int N = 4;
   localparam int V = 2;
   localparam int C = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   in_req;
   logic [2*N-1:0] in_flit_type;
   logic [V-1:0]   credit_return;
   logic [N-1:0]   in_grant;
   logic           out_valid;
   logic [0:0]     out_vc;
   logic [V-1:0]   vc_busy;

   spidergon_vc_arbiter #(
      .NUM_OF_INPUTS(N), .NUM_OF_VIRTUAL_CHANNELS(V), .VC_CREDITS(C)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_req        (in_req),
      .in_flit_type  (in_flit_type),
      .credit_return (credit_return),
      .in_grant      (in_grant),
      .out_valid     (out_valid),
      .out_vc        (out_vc),
      .vc_busy       (vc_busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // flit sources and reference model
   logic [1:0] src_q [N][$];
   int         m_vc_of [N];
   bit         m_busy [V];
   int         m_credit [V];
   int         down_out [V];
   int         m_sa_ptr, m_va_ptr;
   int         cmode;
   logic [V-1:0] forced_ret;
   int         gcount [N];
   int         grant_log [$];
   int         step_no = 0;
   int         last_sel;
   logic [1:0] last_code;
   logic [N-1:0] obs_grant;
   logic [0:0]   obs_vc;
   logic [V-1:0] obs_busy;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_vc_of[i] = -1;
      for (int v = 0; v < V; v++) begin
         m_busy[v] = 1'b0; m_credit[v] = C; down_out[v] = 0;
      end
      m_sa_ptr = 0;
      m_va_ptr = 0;
   endfunction

   function automatic int flits_left();
      int s = 0;
      for (int k = 0; k < N; k++) s += src_q[k].size();
      return s;
   endfunction

   function automatic void clear_sources();
      for (int k = 0; k < N; k++) begin
         src_q[k].delete();
         gcount[k] = 0;
      end
      grant_log.delete();
   endfunction

   function automatic void push_packet(input int i, input int len);
      if (len <= 1) src_q[i].push_back(HEADER);
      else begin
         src_q[i].push_back(HEAD_FLIT);
         for (int b = 0; b < len - 2; b++) src_q[i].push_back(BODY_FLIT);
         src_q[i].push_back(TAIL_FLIT);
      end
   endfunction

   // One clock of stimulus, prediction, comparison and model update (entered at posedge+1).
   task automatic step();
      logic [N-1:0] req, exp_g;
      logic [2*N-1:0] ft;
      logic [V-1:0] ret, exp_busy;
      logic [0:0] exp_vc_b;
      logic [1:0] code;
      int sa_sel, va_sel, free_v, exp_vc, i;
      req = '0; ft = '0;
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() > 0) begin
            req[k] = 1'b1;
            ft[2*k +: 2] = src_q[k][0];
         end
      end
      for (int k = 0; k < V; k++)
         ret[k] = forced_ret[k] || (down_out[k] > 0 && (cmode == 2 || (cmode == 1 && $urandom_range(0, 2) == 0)));
      in_req = req; in_flit_type = ft; credit_return = ret;

      sa_sel = -1;
      for (int k = 0; k < N; k++) begin
         i = (m_sa_ptr + k) % N;
         if (sa_sel < 0 && req[i] && m_vc_of[i] >= 0)
            if (m_credit[m_vc_of[i]] > 0) sa_sel = i;
      end
      free_v = -1;
      for (int k = V - 1; k >= 0; k--) if (!m_busy[k]) free_v = k;
      va_sel = -1;
      for (int k = 0; k < N; k++) begin
         i = (m_va_ptr + k) % N;
         code = ft[2*i +: 2];
         if (va_sel < 0 && free_v >= 0 && req[i] && m_vc_of[i] < 0 && (code == HEAD_FLIT || code == HEADER))
            va_sel = i;
      end
      exp_g = '0; exp_vc = 0;
      if (sa_sel >= 0) begin exp_g[sa_sel] = 1'b1; exp_vc = m_vc_of[sa_sel]; end
      exp_vc_b = 1'(exp_vc);
      for (int k = 0; k < V; k++) exp_busy[k] = m_busy[k];

      @(negedge clk);
      obs_grant = in_grant; obs_vc = out_vc; obs_busy = vc_busy;
      checks++;
      if (in_grant !== exp_g) begin errors++; $display("FAIL in_grant step %0d: got %b want %b", step_no, in_grant, exp_g); end
      checks++;
      if (out_valid !== (sa_sel >= 0)) begin errors++; $display("FAIL out_valid step %0d: got %b want %b", step_no, out_valid, sa_sel >= 0); end
      checks++;
      if (out_vc !== exp_vc_b) begin errors++; $display("FAIL out_vc step %0d: got %0d want %0d", step_no, out_vc, exp_vc_b); end
      checks++;
      if (vc_busy !== exp_busy) begin errors++; $display("FAIL vc_busy step %0d: got %b want %b", step_no, vc_busy, exp_busy); end
      if (sa_sel >= 0)
         $display("step %0d: grant input %0d vc %0d code %b", step_no, sa_sel, exp_vc, ft[2*sa_sel +: 2]);

      @(posedge clk); #1;
      last_sel = sa_sel;
      last_code = 2'b00;
      if (sa_sel >= 0) begin
         code = src_q[sa_sel].pop_front();
         last_code = code;
         gcount[sa_sel]++;
         grant_log.push_back(sa_sel);
         down_out[exp_vc]++;
         if (code == TAIL_FLIT || code == HEADER) begin
            m_busy[exp_vc] = 1'b0;
            m_vc_of[sa_sel] = -1;
         end
`ifndef NOC_ARB_FIXED_PRIO_EN
         m_sa_ptr = (sa_sel + 1) % N;
`endif
      end
      for (int k = 0; k < V; k++) begin
         bit g;
         g = (sa_sel >= 0 && exp_vc == k);
         if (ret[k] && !g) begin
            if (m_credit[k] < C) m_credit[k]++;
         end else if (g && !ret[k]) m_credit[k]--;
         if (ret[k] && down_out[k] > 0) down_out[k]--;
      end
      if (va_sel >= 0) begin
         m_vc_of[va_sel] = free_v;
         m_busy[free_v] = 1'b1;
`ifndef NOC_ARB_FIXED_PRIO_EN
         m_va_ptr = (va_sel + 1) % N;
`endif
      end
      forced_ret = '0;
      step_no++;
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if (in_grant !== '0) begin errors++; $display("FAIL %s in_grant: got %b want 0", tag, in_grant); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %b want 0", tag, out_valid); end
      checks++;
      if (out_vc !== 1'b0) begin errors++; $display("FAIL %s out_vc: got %0d want 0", tag, out_vc); end
      checks++;
      if (vc_busy !== '0) begin errors++; $display("FAIL %s vc_busy: got %b want 0", tag, vc_busy); end
   endtask

   // Asynchronous reset in the middle of a cycle, entered at posedge+1.
   task automatic apply_reset(input string tag);
      #2 reset = 1'b0;
      in_req = '0; in_flit_type = '0; credit_return = '0;
      #1 check_outputs_zero(tag);
      model_reset();
      forced_ret = '0;
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic drain(input int max_steps, input string tag);
      int n = 0;
      while (flits_left() > 0 && n < max_steps) begin step(); n++; end
      checks++;
      if (flits_left() != 0) begin errors++; $display("FAIL %s drain: got %0d flits left want 0", tag, flits_left()); end
   endtask

   task automatic test_reset();
      reset = 1'b0; in_req = '0; in_flit_type = '0; credit_return = '0; forced_ret = '0;
      cmode = 0;
      #3 check_outputs_zero("reset_initial");
      model_reset();
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_header();
      clear_sources();
      cmode = 2;
      src_q[1].push_back(HEADER);
      step();
      checks++;
      if (obs_grant !== 4'b0000 || obs_busy !== 2'b00) begin errors++; $display("FAIL hdr_c0: got grant %b busy %b want 0000 00", obs_grant, obs_busy); end
      step();
      checks++;
      if (obs_grant !== 4'b0010 || obs_vc !== 1'b0 || obs_busy !== 2'b01) begin
         errors++; $display("FAIL hdr_c1: got grant %b vc %0d busy %b want 0010 0 01", obs_grant, obs_vc, obs_busy);
      end
      step();
      checks++;
      if (obs_busy !== 2'b00 || obs_grant !== 4'b0000) begin errors++; $display("FAIL hdr_c2: got busy %b grant %b want 00 0000", obs_busy, obs_grant); end
      drain(10, "single_header");
   endtask

   task automatic test_two_heads();
      int exp_seq [8] = '{1, 2, 1, 2, 1, 2, 1, 2};
      apply_reset("reset_two_heads");
      clear_sources();
      cmode = 2;
      push_packet(1, 4);
      push_packet(2, 4);
      drain(40, "two_heads");
      checks++;
      if (grant_log.size() != 8) begin errors++; $display("FAIL two_heads count: got %0d want 8", grant_log.size()); end
`ifndef NOC_ARB_FIXED_PRIO_EN
      else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant_log[k] != exp_seq[k]) begin errors++; $display("FAIL two_heads order %0d: got %0d want %0d", k, grant_log[k], exp_seq[k]); end
         end
      end
`endif
   endtask

   task automatic test_credit_stall();
      apply_reset("reset_credit_stall");
      clear_sources();
      cmode = 0;
      src_q[0].push_back(HEAD_FLIT);
      repeat (3) src_q[0].push_back(BODY_FLIT);
      repeat (6) step();
      checks++;
      if (gcount[0] != 2) begin errors++; $display("FAIL credit_stall first: got %0d grants want 2", gcount[0]); end
      forced_ret = 2'b01;
      step();
      repeat (4) step();
      checks++;
      if (gcount[0] != 3) begin errors++; $display("FAIL credit_stall refill: got %0d grants want 3", gcount[0]); end
   endtask

   task automatic test_vc_contention();
      bit found = 1'b0;
      int n = 0;
      apply_reset("reset_contention");
      clear_sources();
      cmode = 2;
      for (int k = 0; k < N; k++) push_packet(k, 3);
      while (!found && n < 30) begin
         step(); n++;
         if (last_sel == 0 && last_code == TAIL_FLIT) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL contention tail: got no tail grant in %0d steps want one", n); end
      else begin
         step();
         checks++;
         if (obs_busy !== 2'b10) begin errors++; $display("FAIL contention freed: got busy %b want 10", obs_busy); end
         step();
         checks++;
         if (obs_busy[0] !== 1'b1) begin errors++; $display("FAIL contention realloc: got busy %b want VC0 busy", obs_busy); end
      end
      drain(60, "contention");
   endtask

   task automatic test_credit_overflow();
      apply_reset("reset_overflow");
      clear_sources();
      cmode = 0;
      forced_ret = 2'b01;
      step();
      push_packet(0, 6);
      repeat (5) step();
      checks++;
      if (gcount[0] != 2) begin errors++; $display("FAIL overflow saturate: got %0d grants want 2", gcount[0]); end
      forced_ret = 2'b01;
      step();
      forced_ret = 2'b01;
      step();
      step();
      step();
      checks++;
      if (gcount[0] != 4) begin errors++; $display("FAIL same_cycle credit: got %0d grants want 4", gcount[0]); end
      checks++;
      if (obs_grant !== 4'b0000) begin errors++; $display("FAIL same_cycle stall: got %b want 0000", obs_grant); end
   endtask

   task automatic test_reset_midpacket();
      int n = 0;
      int g0;
      apply_reset("reset_pre_midpacket");
      clear_sources();
      cmode = 2;
      push_packet(0, 6);
      push_packet(1, 6);
      obs_busy = '0;
      while (obs_busy !== 2'b11 && n < 10) begin step(); n++; end
      checks++;
      if (obs_busy !== 2'b11) begin errors++; $display("FAIL midpacket busy: got %b want 11", obs_busy); end
      apply_reset("reset_midpacket");
      g0 = gcount[0];
      repeat (5) step();
      checks++;
      if (gcount[0] != g0) begin errors++; $display("FAIL midpacket body: got %0d grants want %0d", gcount[0], g0); end
      apply_reset("reset_post_midpacket");
      clear_sources();
   endtask

   task automatic test_random();
      apply_reset("reset_random");
      clear_sources();
      cmode = 1;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++)
            if (src_q[k].size() == 0 && $urandom_range(0, 3) == 0)
               push_packet(k, int'($urandom_range(1, 4)));
         step();
      end
      drain(300, "random");
   endtask

   initial begin
      test_reset();
      test_single_header();
      test_two_heads();
      test_credit_stall();
      test_vc_contention();
      test_credit_overflow();
      test_reset_midpacket();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench did not complete");
   end

endmodule
